// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg
// Registered N-input, WIDTH-bit multiplexer with an active-low enable and a
// round-robin scan mode that holds each channel for DWELL enabled cycles.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset, priority over everything
//   en_n       - active-low enable; high freezes the block
//   mode       - 0 = direct select via sel, 1 = round-robin scan
//   sel        - channel index used in direct mode
//   din        - flattened inputs, channel k at din[k*WIDTH +: WIDTH]
//   dout       - registered selected data
//   dout_valid - dout was updated this cycle from a legal channel
//   cur_sel    - index of the channel currently held in dout
//   scan_wrap  - pulse on the last dwell cycle of channel N_IN-1 in scan
//   sel_err    - pulse when direct mode presents sel >= N_IN while enabled
module mux_nx1_reg #(
    parameter  int WIDTH = 4,
    parameter  int N_IN  = 2,
    parameter  int DWELL = 1,
    localparam int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_IN*WIDTH-1:0]   din,
    output logic [WIDTH-1:0]        dout,
    output logic                    dout_valid,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    scan_wrap,
    output logic                    sel_err
);

    localparam int DW_W = $clog2(DWELL) + 1;

    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic [SEL_W-1:0] cur_sel_q,    cur_sel_d;
    logic             scan_wrap_q,  scan_wrap_d;
    logic             sel_err_q,    sel_err_d;
    logic [SEL_W-1:0] ptr_q,        ptr_d;
    logic [DW_W-1:0]  dwell_cnt_q,  dwell_cnt_d;

    // Compare-based channel pick: an index outside 0..N_IN-1 matches no
    // channel and yields zero instead of an out-of-range part-select.
    function automatic logic [WIDTH-1:0] pick_chan(
        input logic [N_IN*WIDTH-1:0] bus,
        input logic [SEL_W-1:0]      idx
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (idx == SEL_W'(k)) begin
                r = bus[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    always_comb begin
        dout_d       = dout_q;
        cur_sel_d    = cur_sel_q;
        dout_valid_d = 1'b0;
        scan_wrap_d  = 1'b0;
        sel_err_d    = 1'b0;
        ptr_d        = ptr_q;
        dwell_cnt_d  = dwell_cnt_q;

        if (!mode) begin
            // Direct mode keeps the scan parked at channel 0 with a fresh
            // dwell, so entering scan always starts from the beginning.
            ptr_d       = '0;
            dwell_cnt_d = '0;
            if (!en_n) begin
                if (int'(sel) < N_IN) begin
                    dout_d       = pick_chan(din, sel);
                    cur_sel_d    = sel;
                    dout_valid_d = 1'b1;
                end else begin
                    sel_err_d    = 1'b1;
                end
            end
        end else if (!en_n) begin
            dout_d       = pick_chan(din, ptr_q);
            cur_sel_d    = ptr_q;
            dout_valid_d = 1'b1;
            if (dwell_cnt_q == DW_W'(DWELL - 1)) begin
                dwell_cnt_d = '0;
                // Explicit wrap compare handles non-power-of-two N_IN.
                if (ptr_q == SEL_W'(N_IN - 1)) begin
                    ptr_d       = '0;
                    scan_wrap_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end else begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            cur_sel_q    <= '0;
            scan_wrap_q  <= 1'b0;
            sel_err_q    <= 1'b0;
            ptr_q        <= '0;
            dwell_cnt_q  <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            cur_sel_q    <= cur_sel_d;
            scan_wrap_q  <= scan_wrap_d;
            sel_err_q    <= sel_err_d;
            ptr_q        <= ptr_d;
            dwell_cnt_q  <= dwell_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign cur_sel    = cur_sel_q;
    assign scan_wrap  = scan_wrap_q;
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_reg.sv
module tb_mux_nx1_reg;

    localparam int WIDTH = 4;
    localparam int N_IN  = 3;
    localparam int DWELL = 2;
    localparam int SEL_W = 2;

    logic                  clk;
    logic                  rst;
    logic                  en_n;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_IN*WIDTH-1:0] din;
    logic [WIDTH-1:0]      dout;
    logic                  dout_valid;
    logic [SEL_W-1:0]      cur_sel;
    logic                  scan_wrap;
    logic                  sel_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: outputs plus the number of enabled scan cycles
    // since scan was (re)entered; channel and wrap derive from that count.
    logic [WIDTH-1:0] m_dout;
    logic             m_valid;
    int               m_cur;
    logic             m_wrap;
    logic             m_err;
    int               m_scan_n;

    mux_nx1_reg #(.WIDTH(WIDTH), .N_IN(N_IN), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_n       (en_n),
        .mode       (mode),
        .sel        (sel),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .cur_sel    (cur_sel),
        .scan_wrap  (scan_wrap),
        .sel_err    (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic e, input logic m,
                              input int s, input logic [N_IN*WIDTH-1:0] d);
        int ch;
        if (r) begin
            m_dout = '0; m_valid = 0; m_cur = 0; m_wrap = 0; m_err = 0; m_scan_n = 0;
        end else if (!m) begin
            m_scan_n = 0;
            m_wrap   = 0;
            m_valid  = 0;
            m_err    = 0;
            if (!e) begin
                if (s < N_IN) begin
                    m_dout  = d[s*WIDTH +: WIDTH];
                    m_cur   = s;
                    m_valid = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            m_err   = 0;
            m_valid = 0;
            m_wrap  = 0;
            if (!e) begin
                ch      = (m_scan_n / DWELL) % N_IN;
                m_dout  = d[ch*WIDTH +: WIDTH];
                m_cur   = ch;
                m_valid = 1;
                m_wrap  = ((m_scan_n % (N_IN*DWELL)) == N_IN*DWELL - 1);
                m_scan_n++;
            end
        end
    endtask

    // One clock: drive on the falling edge, update model at the rising edge,
    // compare every output 1 time unit later.
    task automatic cycle(input logic r, input logic e, input logic m,
                         input int s, input logic [N_IN*WIDTH-1:0] d);
        @(negedge clk);
        rst  = r;
        en_n = e;
        mode = m;
        sel  = SEL_W'(s);
        din  = d;
        @(posedge clk);
        model_step(r, e, m, s, d);
        #1;
        chk("model_dout",  32'(dout),       32'(m_dout));
        chk("model_valid", 32'(dout_valid), 32'(m_valid));
        chk("model_cur",   32'(cur_sel),    32'(m_cur));
        chk("model_wrap",  32'(scan_wrap),  32'(m_wrap));
        chk("model_err",   32'(sel_err),    32'(m_err));
    endtask

    // Directly stated expectations from the test plan.
    task automatic expect_out(input string tag, input int d, input int v,
                              input int c, input int w, input int er);
        chk({tag, "_dout"},  32'(dout),       32'(d));
        chk({tag, "_valid"}, 32'(dout_valid), 32'(v));
        chk({tag, "_cur"},   32'(cur_sel),    32'(c));
        chk({tag, "_wrap"},  32'(scan_wrap),  32'(w));
        chk({tag, "_err"},   32'(sel_err),    32'(er));
    endtask

    localparam logic [N_IN*WIDTH-1:0] CH = 12'hCBA;

    initial begin
        logic r_r, e_r, m_r;
        int   s_r;
        rst = 1'b1; en_n = 1'b0; mode = 1'b0; sel = '0; din = CH;
        m_dout = '0; m_valid = 0; m_cur = 0; m_wrap = 0; m_err = 0; m_scan_n = 0;

        // Reset with mode/sel toggling
        cycle(1, 0, 0, 0, CH); expect_out("rst0", 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 3, CH); expect_out("rst1", 0, 0, 0, 0, 0);

        // Direct select 2,0,1
        cycle(0, 0, 0, 2, CH); expect_out("dir2", 'hC, 1, 2, 0, 0);
        cycle(0, 0, 0, 0, CH); expect_out("dir0", 'hA, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, CH); expect_out("dir1", 'hB, 1, 1, 0, 0);

        // Out-of-range select holds data and pulses sel_err
        cycle(0, 0, 0, 3, CH); expect_out("oor", 'hB, 0, 1, 0, 1);
        cycle(0, 0, 0, 1, CH); expect_out("oor_after", 'hB, 1, 1, 0, 0);

        // Scan sweep A,A,B,B,C,C then A
        cycle(0, 0, 1, 0, CH); expect_out("sw1", 'hA, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("sw2", 'hA, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("sw3", 'hB, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("sw4", 'hB, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("sw5", 'hC, 1, 2, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("sw6", 'hC, 1, 2, 1, 0);
        cycle(0, 0, 1, 0, CH); expect_out("sw7", 'hA, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("sw8", 'hA, 1, 0, 0, 0);

        // Enable pause after the first ch1 cycle
        cycle(0, 0, 1, 0, CH); expect_out("pz_b1", 'hB, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 0, CH); expect_out("pz_hold", 'hB, 0, 1, 0, 0);
        end
        cycle(0, 0, 1, 0, CH); expect_out("pz_b2", 'hB, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("pz_c", 'hC, 1, 2, 0, 0);

        // Mode 1->0->1 mid-dwell on ch1 restarts at ch0
        cycle(0, 0, 0, 0, CH);
        cycle(0, 0, 1, 0, CH);
        cycle(0, 0, 1, 0, CH);
        cycle(0, 0, 1, 0, CH); expect_out("ms_b", 'hB, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, CH); expect_out("ms_dir", 'hB, 1, 1, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("ms_a1", 'hA, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("ms_a2", 'hA, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("ms_b1", 'hB, 1, 1, 0, 0);

        // Reset during a ch2 dwell, then scan restarts at ch0
        cycle(0, 0, 1, 0, CH);
        cycle(0, 0, 1, 0, CH); expect_out("mr_c", 'hC, 1, 2, 0, 0);
        cycle(1, 0, 1, 0, CH); expect_out("mr_rst", 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("mr_a1", 'hA, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("mr_a2", 'hA, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, CH); expect_out("mr_b", 'hB, 1, 1, 0, 0);

        // Randomized traffic against the model
        m_r = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r_r = ($urandom_range(0, 49) == 0);
            e_r = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) m_r = ~m_r;
            s_r = $urandom_range(0, 3);
            cycle(r_r, e_r, m_r, s_r, N_IN*WIDTH'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nx1_reg.md
# mux_nx1_reg

Parametrised, registered N-input, WIDTH-bit multiplexer with an active-low enable. It generalises our quad 2:1 selector to any channel count and width, and replaces level-sensitive output holding with clean clocked behaviour. It adds a round-robin scan mode that steps through the inputs automatically, holding each channel for a programmable dwell time. It sits between parallel data sources (sensor/register banks) and a single downstream consumer that samples one channel at a time.

## Interface
Parameters:
- WIDTH, 4: bits per channel; ≥1.
- N_IN, 2: number of input channels; ≥2. It need not be a power of two.
- DWELL, 1: enabled cycles spent on each channel in scan mode; ≥1.
- SEL_W is a derived localparam, equal to max(1, clog2(N_IN)). It is not overridable.

Ports:
- clk  in  1  Single clock; all logic is on its rising edge.
- rst  in  1  Reset, synchronous and active-high; has priority over all other inputs.
- en_n  in  1  Active-low enable; 1 freezes the block.
- mode  in  1  0 = direct select, 1 = round-robin scan.
- sel  in  SEL_W  Channel index used in mode 0.
- din  in  N_IN*WIDTH  Flattened inputs; channel k occupies din[k*WIDTH +: WIDTH].
- dout  out  WIDTH  Registered selected data.
- dout_valid  out  1  dout was updated this cycle from a legal channel.
- cur_sel  out  SEL_W  Index of the channel currently held in dout.
- scan_wrap  out  1  One-cycle pulse when channel N_IN-1 finishes its last dwell cycle in scan.
- sel_err  out  1  One-cycle pulse when mode 0 presents sel ≥ N_IN while enabled.

## Operation
Registers are dout, dout_valid, cur_sel, scan_wrap, sel_err, ptr[SEL_W], and dwell_cnt[clog2(DWELL)+1].

Reset (rst=1 at an edge):
- All outputs and internal registers go to 0.
- rst wins over en_n and mode.

Disabled (en_n=1, rst=0):
- dout and cur_sel hold.
- dout_valid=0, scan_wrap=0, sel_err=0.
- In mode 1, ptr and dwell_cnt freeze.

Mode 0, enabled:
- If sel < N_IN: dout←din[sel], cur_sel←sel, dout_valid←1, sel_err←0.
- If sel ≥ N_IN: dout and cur_sel hold, dout_valid←0, sel_err←1.
- scan_wrap←0.

Mode 0, any en_n:
- ptr←0 and dwell_cnt←0.
- As a result, the first scan cycle after entering mode 1 always samples channel 0.

Mode 1, enabled:
- dout←din[ptr], cur_sel←ptr, dout_valid←1, sel_err←0. The sel input is ignored.
- If dwell_cnt == DWELL-1:
  - dwell_cnt←0.
  - ptr←(ptr==N_IN-1) ? 0 : ptr+1.
  - scan_wrap←(ptr==N_IN-1).
- Otherwise: dwell_cnt←dwell_cnt+1 and scan_wrap←0.

Mode 1→0 mid-dwell:
- The scan is abandoned and the next enabled cycle follows mode 0 rules.
- Re-entering mode 1 restarts at channel 0 with a full dwell.

Arithmetic:
- ptr never exceeds N_IN-1. Wrap is an explicit compare, not a natural overflow, so non-power-of-two N_IN is handled.
- Every mux index is bounded; there are no X-producing out-of-range reads.

## Timing
- Latency is 1 cycle: inputs sampled at edge t appear on dout, dout_valid, cur_sel and the pulses after edge t.
- Throughput is one sample per enabled cycle; there is no backpressure.
- dout_valid, scan_wrap and sel_err are single-cycle registered pulses/levels that are recomputed every edge.
- In scan with continuous enable, each channel stays on dout for DWELL consecutive cycles. A full sweep takes N_IN*DWELL cycles, and scan_wrap marks its last cycle.
- en_n pauses stretch a dwell without losing counts; the dwell resumes exactly where it stopped.
- Deasserting rst gives the first functional edge with ptr=0 and dwell_cnt=0.
- Outputs are purely registered, with no combinational path from input to output.

## Test plan
Parameters for all scenarios: WIDTH=4, N_IN=3, DWELL=2, channel values din = {ch2=0xC, ch1=0xB, ch0=0xA}.

- **Reset:** rst=1 for 2 cycles, with mode and sel toggling → dout=0, dout_valid=0, cur_sel=0, scan_wrap=0, sel_err=0 throughout.
- **Direct select:** mode=0, en_n=0, sel=2,0,1 on consecutive edges → dout=0xC,0xA,0xB and cur_sel=2,0,1, each one cycle later, with dout_valid=1.
- **Out-of-range select:** mode=0, sel=1 then sel=3 → after the second edge, dout stays 0xB, dout_valid=0, sel_err=1 for one cycle.
- **Scan sweep:** mode=1, en_n=0 for 6 cycles → dout=A,A,B,B,C,C; cur_sel=0,0,1,1,2,2; scan_wrap=1 only on the 6th cycle; then dout=A again.
- **Enable pause:** in scan, en_n=1 for 3 cycles after the first ch1 cycle → dout holds 0xB with dout_valid=0 during the pause; after the pause, exactly one more 0xB cycle, then 0xC.
- **Mode switch and mid-run reset:** mode 1→0→1 mid-dwell on ch1 → the scan restarts at ch0 for 2 cycles. Separately, rst=1 during a ch2 dwell → all registers are 0, and the next scan starts at ch0.
